// File: rtl/fpga_link_pkg.sv
// Shared definitions for the FPGA-to-FPGA serial link (transmitter and receiver).
// Holds the receiver state encoding and the default frame/timeout sizes.
package fpga_link_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    SAMPLE,
    ACK,
    DONE
  } rx_state_t;

endpackage

// File: rtl/fpga_rx_sync.sv
// Two-flop synchronizer for a single bit crossing into clk.
// Both flops clear on reset; output lags the input by two clk edges.
module fpga_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fpga_receiver.sv
// Serial-link receiver: 4-phase ack per bit, LSB-first word assembly, timeout abort.
// Define FPGA_RX_SYNC_EN to pass req_in/data_in through 2-flop synchronizers (+2 cycles latency).
module fpga_receiver
  import fpga_link_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_in,
  input  logic              data_in,
  output logic              ack_out,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  logic              req_s;
  logic              data_s;
  rx_state_t         state;
  logic [CNT_W-1:0]  count;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] shreg;
  logic              rearm;

`ifdef FPGA_RX_SYNC_EN
  fpga_rx_sync u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (req_in),
    .q     (req_s)
  );

  fpga_rx_sync u_data_sync (
    .clk   (clk),
    .reset (reset),
    .d     (data_in),
    .q     (data_s)
  );
`else
  assign req_s  = req_in;
  assign data_s = data_in;
`endif

  assign ack_out = (state == ACK);
  assign busy    = (state != IDLE);

  // rearm blocks a restart while req is still held from a bit aborted in ACK,
  // so a new frame only begins on a fresh rising req_s.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      timer     <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rearm     <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (!req_s) begin
        rearm <= 1'b0;
      end
      if (timer != TMR_MAX) begin
        timer <= timer + 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_s && !rearm) begin
            state <= SAMPLE;
            timer <= '0;
          end
        end

        WAIT_REQ: begin
          if (req_s) begin
            state <= SAMPLE;
            timer <= '0;
          end else if (timer == TMR_LAST) begin
            state     <= IDLE;
            timer     <= '0;
            count     <= '0;
            frame_err <= 1'b1;
          end
        end

        SAMPLE: begin
          shreg <= {data_s, shreg[DATA_W-1:1]};
          count <= count + 1'b1;
          state <= ACK;
          timer <= '0;
        end

        ACK: begin
          if (!req_s) begin
            timer <= '0;
            if (count == CNT_FULL) begin
              state    <= DONE;
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              state <= WAIT_REQ;
            end
          end else if (timer == TMR_LAST) begin
            state     <= IDLE;
            timer     <= '0;
            count     <= '0;
            frame_err <= 1'b1;
            rearm     <= 1'b1;
          end
        end

        DONE: begin
          count <= '0;
          state <= IDLE;
          timer <= '0;
        end

        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
